// File: rtl/iob_plic_claim_master.sv
// IOb initiator that claims, dispatches and completes interrupts from one iob_plic target.
// Optional claim-read timeout: define PLIC_CLAIM_TIMEOUT_EN.
module iob_plic_claim_master #(
   parameter int unsigned       ADDR_W     = 16,
   parameter int unsigned       DATA_W     = 32,
   parameter int unsigned       N_SOURCES  = 8,
   parameter logic [ADDR_W-1:0] CLAIM_ADDR = '0,
   parameter int unsigned       CNT_W      = 8,
   parameter int unsigned       TIMEOUT    = 64,
   localparam int unsigned      ID_W       = $clog2(N_SOURCES + 1)
) (
   input  logic                clk_i,
   input  logic                arst_i,
   input  logic                en_i,
   input  logic                meip_i,
   output logic                iob_avalid_o,
   output logic [ADDR_W-1:0]   iob_addr_o,
   output logic [DATA_W-1:0]   iob_wdata_o,
   output logic [DATA_W/8-1:0] iob_wstrb_o,
   input  logic                iob_rvalid_i,
   input  logic [DATA_W-1:0]   iob_rdata_i,
   input  logic                iob_ready_i,
   output logic                irq_valid_o,
   output logic [ID_W-1:0]     irq_id_o,
   input  logic                irq_done_i,
   output logic                busy_o,
   output logic [CNT_W-1:0]    claim_cnt_o,
   output logic [CNT_W-1:0]    spurious_cnt_o,
   output logic                err_o
);

   typedef enum logic [2:0] {
      IDLE,
      CLAIM_REQ,
      CLAIM_WAIT,
      DISPATCH,
      COMPLETE
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic [ID_W-1:0]  irq_id_q, irq_id_d;
   logic [CNT_W-1:0] claim_cnt_q, claim_cnt_d;
   logic [CNT_W-1:0] spurious_cnt_q, spurious_cnt_d;
   logic [ID_W-1:0]  rd_id;
   logic             timed_out;

   assign rd_id = iob_rdata_i[ID_W-1:0];

   logic unused_rdata;
   assign unused_rdata = ^iob_rdata_i[DATA_W-1:ID_W];

`ifdef PLIC_CLAIM_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             err_q, err_d;

   // Counts CLAIM_WAIT cycles; cleared whenever the FSM is elsewhere.
   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == CLAIM_WAIT) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
   end

   assign timed_out = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
   assign err_d     = (state_q == CLAIM_WAIT) && !iob_rvalid_i && timed_out;
   assign err_o     = err_q;

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         err_q     <= err_d;
      end
   end
`else
   logic [31:0] unused_tmo;
   assign unused_tmo = TIMEOUT;
   assign timed_out  = 1'b0;
   assign err_o      = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      irq_id_d       = irq_id_q;
      claim_cnt_d    = claim_cnt_q;
      spurious_cnt_d = spurious_cnt_q;
      unique case (state_q)
         IDLE: if (en_i && meip_i) state_d = CLAIM_REQ;
         CLAIM_REQ: if (iob_ready_i) state_d = CLAIM_WAIT;
         CLAIM_WAIT: begin
            if (iob_rvalid_i) begin
               if (rd_id == '0) begin
                  if (spurious_cnt_q != '1)
                     spurious_cnt_d = spurious_cnt_q + CNT_W'(1);
                  state_d = IDLE;
               end else begin
                  irq_id_d    = rd_id;
                  claim_cnt_d = claim_cnt_q + CNT_W'(1);
                  state_d     = DISPATCH;
               end
            end else if (timed_out) begin
               state_d = IDLE;
            end
         end
         DISPATCH: if (irq_done_i) state_d = COMPLETE;
         COMPLETE: if (iob_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         state_q        <= IDLE;
         busy_q         <= 1'b0;
         irq_id_q       <= '0;
         claim_cnt_q    <= '0;
         spurious_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         busy_q         <= busy_d;
         irq_id_q       <= irq_id_d;
         claim_cnt_q    <= claim_cnt_d;
         spurious_cnt_q <= spurious_cnt_d;
      end
   end

   // Request fields read as zero whenever no request is pending.
   always_comb begin
      iob_avalid_o = 1'b0;
      iob_addr_o   = '0;
      iob_wdata_o  = '0;
      iob_wstrb_o  = '0;
      if (state_q == CLAIM_REQ) begin
         iob_avalid_o = 1'b1;
         iob_addr_o   = CLAIM_ADDR;
      end else if (state_q == COMPLETE) begin
         iob_avalid_o = 1'b1;
         iob_addr_o   = CLAIM_ADDR;
         iob_wdata_o  = {{(DATA_W - ID_W){1'b0}}, irq_id_q};
         iob_wstrb_o  = '1;
      end
   end

   assign irq_valid_o    = (state_q == DISPATCH);
   assign irq_id_o       = irq_id_q;
   assign busy_o         = busy_q;
   assign claim_cnt_o    = claim_cnt_q;
   assign spurious_cnt_o = spurious_cnt_q;

endmodule

// File: tb/tb_iob_plic_claim_master.sv
// Bench for iob_plic_claim_master: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_iob_plic_claim_master;

   localparam int          TIMEOUT = 64;
   localparam logic [15:0] CADDR   = 16'h0040;

   logic        clk = 1'b0;
   logic        arst_i = 1'b1;
   logic        en_i = 1'b1;
   logic        meip_i = 1'b0;
   logic        iob_avalid_o;
   logic [15:0] iob_addr_o;
   logic [31:0] iob_wdata_o;
   logic [3:0]  iob_wstrb_o;
   logic        iob_rvalid_i = 1'b0;
   logic [31:0] iob_rdata_i = '0;
   logic        iob_ready_i = 1'b0;
   logic        irq_valid_o;
   logic [3:0]  irq_id_o;
   logic        irq_done_i = 1'b0;
   logic        busy_o;
   logic [7:0]  claim_cnt_o;
   logic [7:0]  spurious_cnt_o;
   logic        err_o;

   iob_plic_claim_master #(
      .ADDR_W(16), .DATA_W(32), .N_SOURCES(8),
      .CLAIM_ADDR(CADDR), .CNT_W(8), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk), .arst_i(arst_i), .en_i(en_i), .meip_i(meip_i),
      .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
      .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
      .iob_rvalid_i(iob_rvalid_i), .iob_rdata_i(iob_rdata_i),
      .iob_ready_i(iob_ready_i), .irq_valid_o(irq_valid_o),
      .irq_id_o(irq_id_o), .irq_done_i(irq_done_i), .busy_o(busy_o),
      .claim_cnt_o(claim_cnt_o), .spurious_cnt_o(spurious_cnt_o),
      .err_o(err_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;
   int n_rd = 0;
   int n_wr = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Transaction-level model: which request is outstanding, what the handler holds.
   bit m_rd_req, m_rd_wait, m_disp, m_wr_req, m_err;
   int m_id, m_claims, m_spur, m_wait_cyc;

   always @(posedge clk) begin
      m_err = 1'b0;
      if (arst_i) begin
         m_rd_req = 0; m_rd_wait = 0; m_disp = 0; m_wr_req = 0;
         m_id = 0; m_claims = 0; m_spur = 0; m_wait_cyc = 0;
      end else if (m_rd_req) begin
         if (iob_ready_i) begin
            m_rd_req = 0; m_rd_wait = 1; m_wait_cyc = 0;
         end
      end else if (m_rd_wait) begin
         if (iob_rvalid_i) begin
            m_rd_wait = 0;
            if ((iob_rdata_i & 32'hF) == 0) begin
               m_spur = (m_spur < 255) ? m_spur + 1 : 255;
            end else begin
               m_id = int'(iob_rdata_i & 32'hF);
               m_claims = (m_claims + 1) % 256;
               m_disp = 1;
            end
         end else begin
            m_wait_cyc++;
`ifdef PLIC_CLAIM_TIMEOUT_EN
            if (m_wait_cyc == TIMEOUT) begin
               m_rd_wait = 0; m_err = 1;
            end
`endif
         end
      end else if (m_disp) begin
         if (irq_done_i) begin
            m_disp = 0; m_wr_req = 1;
         end
      end else if (m_wr_req) begin
         if (iob_ready_i) m_wr_req = 0;
      end else if (en_i && meip_i) begin
         m_rd_req = 1;
      end
   end

   always @(posedge clk) begin
      if (!arst_i && iob_avalid_o && iob_ready_i) begin
         if (iob_wstrb_o == 0) n_rd++;
         else n_wr++;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("avalid", iob_avalid_o, m_rd_req | m_wr_req);
         chk("addr", iob_addr_o, (m_rd_req | m_wr_req) ? CADDR : 16'h0);
         chk("wdata", iob_wdata_o, m_wr_req ? m_id : 0);
         chk("wstrb", iob_wstrb_o, m_wr_req ? 4'hF : 4'h0);
         chk("irq_valid", irq_valid_o, m_disp);
         chk("irq_id", irq_id_o, m_id);
         chk("busy", busy_o, m_rd_req | m_rd_wait | m_disp | m_wr_req);
         chk("claim_cnt", claim_cnt_o, m_claims);
         chk("spurious_cnt", spurious_cnt_o, m_spur);
         chk("err", err_o, m_err);
      end
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic wait_av(input bit wr, input int max);
      for (int i = 0; i < max; i++) begin
         if (iob_avalid_o && ((iob_wstrb_o != 0) == wr)) return;
         tick;
      end
      n_chk++;
      n_err++;
      $display("FAIL wait_av: no %s request within %0d cycles",
               wr ? "write" : "read", max);
   endtask

   // One full claim; rdly/wdly = ready-low cycles, ddly = cycles before done.
   task automatic run_claim(input logic [31:0] rd, input int rdly,
                            input int ddly, input int wdly);
      logic [3:0] id;
      id = rd[3:0];
      meip_i = 1; iob_ready_i = 0;
      wait_av(0, 10);
      repeat (rdly) tick;
      iob_ready_i = 1;
      tick;
      iob_ready_i = 0; meip_i = 0;
      iob_rvalid_i = 1; iob_rdata_i = rd;
      tick;
      iob_rvalid_i = 0; iob_rdata_i = '0;
      if (id != 0) begin
         chk("dispatch_id", irq_id_o, id);
         repeat (ddly) tick;
         irq_done_i = 1;
         tick;
         irq_done_i = 0;
         repeat (wdly) tick;
         chk("wr_data", iob_wdata_o, id);
         chk("wr_addr", iob_addr_o, CADDR);
         iob_ready_i = 1;
         tick;
         iob_ready_i = 0;
      end
      tick;
   endtask

   int rd0, wr0, cyc;

   initial begin
      repeat (3) tick;
      cmp_en = 1;
      chk("rst_avalid", iob_avalid_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_claim", claim_cnt_o, 0);
      chk("rst_spur", spurious_cnt_o, 0);
      chk("rst_irq_id", irq_id_o, 0);
      arst_i = 0;
      tick;

      // Basic: latency meip -> irq_valid is 3 cycles
      meip_i = 1; iob_ready_i = 1;
      tick; tick;
      meip_i = 0; iob_ready_i = 0;
      iob_rvalid_i = 1; iob_rdata_i = 32'd5;
      tick;
      iob_rvalid_i = 0; iob_rdata_i = 0;
      chk("t1_irq_valid", irq_valid_o, 1);
      chk("t1_irq_id", irq_id_o, 4'd5);
      tick; tick;
      irq_done_i = 1;
      tick;
      irq_done_i = 0;
      chk("t1_wdata", iob_wdata_o, 32'd5);
      chk("t1_wstrb", iob_wstrb_o, 4'hF);
      chk("t1_addr", iob_addr_o, CADDR);
      iob_ready_i = 1;
      tick;
      iob_ready_i = 0;
      tick;
      chk("t1_claim", claim_cnt_o, 1);
      chk("t1_wr", n_wr, 1);

      // Spurious, with junk above the ID field
      wr0 = n_wr;
      run_claim(32'hABCD_0100, 0, 0, 0);
      chk("t2_spur", spurious_cnt_o, 1);
      chk("t2_nowr", n_wr, wr0);
      chk("t2_busy", busy_o, 0);

      // Backpressure on both requests; high bits ignored
      rd0 = n_rd; wr0 = n_wr;
      run_claim(32'hFFFF_FF03, 4, 1, 4);
      chk("t3_rd", n_rd, rd0 + 1);
      chk("t3_wr", n_wr, wr0 + 1);
      chk("t3_claim", claim_cnt_o, 2);

      // en_i dropped in DISPATCH
      meip_i = 1; iob_ready_i = 1;
      wait_av(0, 10);
      tick;
      iob_ready_i = 0;
      iob_rvalid_i = 1; iob_rdata_i = 32'd2;
      tick;
      iob_rvalid_i = 0; iob_rdata_i = 0;
      en_i = 0;
      tick;
      irq_done_i = 1;
      tick;
      irq_done_i = 0;
      wait_av(1, 3);
      iob_ready_i = 1;
      tick;
      iob_ready_i = 0;
      rd0 = n_rd;
      repeat (6) tick;
      chk("t4_noclaim", n_rd, rd0);
      chk("t4_idle", busy_o, 0);
      chk("t4_wr", iob_avalid_o, 0);
      en_i = 1;
      wait_av(0, 5);
      iob_ready_i = 1;
      tick;
      iob_ready_i = 0; meip_i = 0;
      iob_rvalid_i = 1;
      tick;
      iob_rvalid_i = 0;
      tick;
      chk("t4_claim", claim_cnt_o, 3);
      chk("t4_spur", spurious_cnt_o, 2);

      // Counter wrap and saturation
      for (int i = 0; i < 256; i++) run_claim(32'(i % 8 + 1), 0, 0, 0);
      chk("wrap_claim", claim_cnt_o, 3);
      for (int i = 0; i < 300; i++) run_claim(32'h0, 0, 0, 0);
      chk("sat_spur", spurious_cnt_o, 255);

      // Reset in CLAIM_WAIT, then late rvalid
      meip_i = 1; iob_ready_i = 1;
      wait_av(0, 10);
      tick;
      iob_ready_i = 0; meip_i = 0;
      arst_i = 1;
      tick;
      arst_i = 0;
      chk("t5a_busy", busy_o, 0);
      chk("t5a_claim", claim_cnt_o, 0);
      chk("t5a_spur", spurious_cnt_o, 0);
      iob_rvalid_i = 1; iob_rdata_i = 32'd7;
      tick;
      iob_rvalid_i = 0; iob_rdata_i = 0;
      tick;
      chk("t5a_late", claim_cnt_o, 0);
      chk("t5a_irq", irq_valid_o, 0);

      // Reset in DISPATCH
      wr0 = n_wr;
      meip_i = 1; iob_ready_i = 1;
      wait_av(0, 10);
      tick;
      iob_ready_i = 0; meip_i = 0;
      iob_rvalid_i = 1; iob_rdata_i = 32'd6;
      tick;
      iob_rvalid_i = 0; iob_rdata_i = 0;
      chk("t5b_disp", irq_valid_o, 1);
      arst_i = 1;
      tick;
      arst_i = 0;
      chk("t5b_irq", irq_valid_o, 0);
      chk("t5b_claim", claim_cnt_o, 0);
      irq_done_i = 1;
      tick;
      irq_done_i = 0;
      repeat (3) tick;
      chk("t5b_nowr", n_wr, wr0);

`ifdef PLIC_CLAIM_TIMEOUT_EN
      meip_i = 1; iob_ready_i = 1;
      wait_av(0, 10);
      tick;
      iob_ready_i = 0; meip_i = 0;
      cyc = 0;
      for (int i = 1; i <= 100; i++) begin
         tick;
         if (err_o) begin
            cyc = i;
            break;
         end
      end
      chk("t6_err_cyc", cyc, TIMEOUT);
      tick;
      chk("t6_busy", busy_o, 0);
      iob_rvalid_i = 1; iob_rdata_i = 32'd5;
      tick;
      iob_rvalid_i = 0; iob_rdata_i = 0;
      chk("t6_claim", claim_cnt_o, 0);
`endif

      tick;
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
